// File: rtl/copro_issue_sequencer.sv
// ---------------------------------------------------------------------------
// copro_issue_sequencer
//
// Holds coprocessor instructions between issue, commit and execute. Every
// accepted issue request is parked in a slot until the core commits or kills
// it. Committed slots are queued in commit order and handed to the execution
// unit through a valid/ready handshake. A slot is recycled once dispatched.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   issue_*                issue request from the core/decoder; issue_ready_o
//                          is asserted when a slot is free and the offered id
//                          is not already live
//   commit_*               commit (kill=0) or kill (kill=1) of a live id
//   exec_*                 head of the commit queue towards the execution unit
//   spurious_commit_o      one-cycle pulse when a commit matched no pending slot
//   occupancy_o            registered count of slots that are not free
// ---------------------------------------------------------------------------
module copro_issue_sequencer #(
    parameter int NbEntries = 4,
    parameter int IdWidth   = 4,
    parameter int OpWidth   = 4,
    parameter int XLen      = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           issue_valid_i,
    output logic                           issue_ready_o,
    input  logic [IdWidth-1:0]             issue_id_i,
    input  logic                           issue_accept_i,
    input  logic                           issue_writeback_i,
    input  logic [OpWidth-1:0]             issue_op_i,
    input  logic [XLen-1:0]                issue_rs1_i,
    input  logic [XLen-1:0]                issue_rs2_i,
    input  logic                           commit_valid_i,
    input  logic [IdWidth-1:0]             commit_id_i,
    input  logic                           commit_kill_i,
    output logic                           exec_valid_o,
    input  logic                           exec_ready_i,
    output logic [IdWidth-1:0]             exec_id_o,
    output logic [OpWidth-1:0]             exec_op_o,
    output logic [XLen-1:0]                exec_rs1_o,
    output logic [XLen-1:0]                exec_rs2_o,
    output logic                           exec_writeback_o,
    output logic                           spurious_commit_o,
    output logic [$clog2(NbEntries+1)-1:0] occupancy_o
);

    localparam int IdxW = $clog2(NbEntries);
    localparam int CntW = $clog2(NbEntries + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NbEntries - 1);

    localparam logic [1:0] ST_FREE      = 2'd0;
    localparam logic [1:0] ST_PENDING   = 2'd1;
    localparam logic [1:0] ST_COMMITTED = 2'd2;

    logic [1:0]         r_state [NbEntries];
    logic [IdWidth-1:0] r_id    [NbEntries];
    logic [OpWidth-1:0] r_op    [NbEntries];
    logic [XLen-1:0]    r_rs1   [NbEntries];
    logic [XLen-1:0]    r_rs2   [NbEntries];
    logic               r_wb    [NbEntries];

    logic [IdxW-1:0]    r_fifo  [NbEntries];
    logic [IdxW-1:0]    r_rdPtr;
    logic [IdxW-1:0]    r_wrPtr;
    logic [CntW-1:0]    r_fifoCnt;
    logic [CntW-1:0]    r_occ;
    logic               r_spurious;

    logic               w_anyFree;
    logic [IdxW-1:0]    w_freeIdx;
    logic               w_dupHit;
    logic               w_cmtHit;
    logic [IdxW-1:0]    w_cmtIdx;
    logic               w_alloc;
    logic               w_cmtValid;
    logic               w_push;
    logic               w_pop;
    logic [IdxW-1:0]    w_headIdx;
    logic [1:0]         w_stateNext [NbEntries];
    logic [CntW-1:0]    w_occNext;

    function automatic logic [IdxW-1:0] nextPtr(input logic [IdxW-1:0] p);
        return (p == LastIdx) ? '0 : p + 1'b1;
    endfunction

    // Scanning downwards leaves the lowest matching index in the result.
    // Live ids are unique (duplicates stall at issue), so at most one pending
    // slot can match the commit id.
    always_comb begin
        w_anyFree = 1'b0;
        w_freeIdx = '0;
        w_dupHit  = 1'b0;
        w_cmtHit  = 1'b0;
        w_cmtIdx  = '0;
        for (int i = NbEntries - 1; i >= 0; i--) begin
            if (r_state[i] == ST_FREE) begin
                w_anyFree = 1'b1;
                w_freeIdx = IdxW'(i);
            end
            if ((r_state[i] != ST_FREE) && (r_id[i] == issue_id_i)) begin
                w_dupHit = 1'b1;
            end
            if ((r_state[i] == ST_PENDING) && (r_id[i] == commit_id_i)) begin
                w_cmtHit = 1'b1;
                w_cmtIdx = IdxW'(i);
            end
        end
    end

    assign issue_ready_o = w_anyFree & ~w_dupHit;
    assign w_alloc       = issue_valid_i & issue_ready_o & issue_accept_i;
    assign w_cmtValid    = commit_valid_i & w_cmtHit;
    assign w_push        = w_cmtValid & ~commit_kill_i;
    assign w_headIdx     = r_fifo[r_rdPtr];
    assign w_pop         = exec_valid_o & exec_ready_i;

    // Pop, commit and allocation always address slots in three different
    // states (COMMITTED, PENDING, FREE), so the updates never collide.
    always_comb begin
        w_occNext = '0;
        for (int i = 0; i < NbEntries; i++) begin
            w_stateNext[i] = r_state[i];
            if (w_pop && (w_headIdx == IdxW'(i))) begin
                w_stateNext[i] = ST_FREE;
            end
            if (w_cmtValid && (w_cmtIdx == IdxW'(i))) begin
                w_stateNext[i] = commit_kill_i ? ST_FREE : ST_COMMITTED;
            end
            if (w_alloc && (w_freeIdx == IdxW'(i))) begin
                w_stateNext[i] = ST_PENDING;
            end
            if (w_stateNext[i] != ST_FREE) begin
                w_occNext = w_occNext + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NbEntries; i++) begin
                r_state[i] <= ST_FREE;
                r_id[i]    <= '0;
                r_op[i]    <= '0;
                r_rs1[i]   <= '0;
                r_rs2[i]   <= '0;
                r_wb[i]    <= 1'b0;
            end
            r_occ      <= '0;
            r_spurious <= 1'b0;
        end else begin
            for (int i = 0; i < NbEntries; i++) begin
                r_state[i] <= w_stateNext[i];
                if (w_alloc && (w_freeIdx == IdxW'(i))) begin
                    r_id[i]  <= issue_id_i;
                    r_op[i]  <= issue_op_i;
                    r_rs1[i] <= issue_rs1_i;
                    r_rs2[i] <= issue_rs2_i;
                    r_wb[i]  <= issue_writeback_i;
                end
            end
            r_occ      <= w_occNext;
            r_spurious <= commit_valid_i & ~w_cmtHit;
        end
    end

    // Commit-order queue of slot indices. It holds at most one entry per
    // slot, so a depth of NbEntries cannot overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NbEntries; i++) begin
                r_fifo[i] <= '0;
            end
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_fifoCnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wrPtr] <= w_cmtIdx;
                r_wrPtr         <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            if (w_push && !w_pop) begin
                r_fifoCnt <= r_fifoCnt + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_fifoCnt <= r_fifoCnt - CntW'(1);
            end
        end
    end

    // The head slot stays COMMITTED until popped, so its fields are stable
    // while the execution unit applies backpressure.
    assign exec_valid_o      = (r_fifoCnt != '0);
    assign exec_id_o         = r_id[w_headIdx];
    assign exec_op_o         = r_op[w_headIdx];
    assign exec_rs1_o        = r_rs1[w_headIdx];
    assign exec_rs2_o        = r_rs2[w_headIdx];
    assign exec_writeback_o  = r_wb[w_headIdx];
    assign spurious_commit_o = r_spurious;
    assign occupancy_o       = r_occ;

endmodule

// File: tb/tb_copro_issue_sequencer.sv
// ---------------------------------------------------------------------------
// tb_copro_issue_sequencer
//
// Self-checking bench for copro_issue_sequencer (NbEntries=4, IdWidth=4,
// OpWidth=4, XLen=32). A directed vector table covers the basic flow,
// reject, kill and spurious commits; hand-written sequences cover full and
// duplicate stalls, reset mid-operation, commit ordering with backpressure
// and simultaneous events; a randomized phase is compared every cycle
// against a slot/queue reference model.
// ---------------------------------------------------------------------------
module tb_copro_issue_sequencer;

    localparam int NB = 4;

    typedef struct {
        logic        iv;
        logic [3:0]  iid;
        logic        acc;
        logic [3:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        cv;
        logic [3:0]  cid;
        logic        kill;
        logic        er;
        logic        expReady;
        logic        expEv;
        logic [3:0]  expId;
        logic [3:0]  expOp;
        logic [31:0] expRs1;
        logic [31:0] expRs2;
        logic [2:0]  expOcc;
        logic        expSpur;
    } vec_t;

    logic        clk;
    logic        rstN;
    logic        issueValid;
    logic        issueReady;
    logic [3:0]  issueId;
    logic        issueAccept;
    logic        issueWb;
    logic [3:0]  issueOp;
    logic [31:0] issueRs1;
    logic [31:0] issueRs2;
    logic        commitValid;
    logic [3:0]  commitId;
    logic        commitKill;
    logic        execValid;
    logic        execReady;
    logic [3:0]  execId;
    logic [3:0]  execOp;
    logic [31:0] execRs1;
    logic [31:0] execRs2;
    logic        execWb;
    logic        spurious;
    logic [2:0]  occupancy;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: slot table (0 free, 1 pending, 2 committed) plus a
    // queue holding committed slots in commit order.
    int          mState [NB];
    logic [3:0]  mId    [NB];
    logic [3:0]  mOp    [NB];
    logic [31:0] mRs1   [NB];
    logic [31:0] mRs2   [NB];
    logic        mWb    [NB];
    int          mQ [$];
    logic        mSpur;

    vec_t tbl [12];

    copro_issue_sequencer #(
        .NbEntries(NB),
        .IdWidth(4),
        .OpWidth(4),
        .XLen(32)
    ) dut (
        .clk_i(clk),
        .rst_ni(rstN),
        .issue_valid_i(issueValid),
        .issue_ready_o(issueReady),
        .issue_id_i(issueId),
        .issue_accept_i(issueAccept),
        .issue_writeback_i(issueWb),
        .issue_op_i(issueOp),
        .issue_rs1_i(issueRs1),
        .issue_rs2_i(issueRs2),
        .commit_valid_i(commitValid),
        .commit_id_i(commitId),
        .commit_kill_i(commitKill),
        .exec_valid_o(execValid),
        .exec_ready_i(execReady),
        .exec_id_o(execId),
        .exec_op_o(execOp),
        .exec_rs1_o(execRs1),
        .exec_rs2_o(execRs2),
        .exec_writeback_o(execWb),
        .spurious_commit_o(spurious),
        .occupancy_o(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NB; i++) begin
            mState[i] = 0;
            mId[i]    = '0;
            mOp[i]    = '0;
            mRs1[i]   = '0;
            mRs2[i]   = '0;
            mWb[i]    = 1'b0;
        end
        mQ.delete();
        mSpur = 1'b0;
    endtask

    function automatic logic modelReady();
        logic anyFree = 1'b0;
        logic dup = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (mState[i] == 0) anyFree = 1'b1;
            else if (mId[i] == issueId) dup = 1'b1;
        end
        return anyFree && !dup;
    endfunction

    function automatic int modelOcc();
        int n = 0;
        for (int i = 0; i < NB; i++) if (mState[i] != 0) n++;
        return n;
    endfunction

    // Applies this cycle's inputs to the model, all based on pre-edge state.
    task automatic modelStep();
        int allocIdx = -1;
        int cmtIdx = -1;
        if (issueValid && issueAccept && modelReady()) begin
            for (int i = NB - 1; i >= 0; i--) if (mState[i] == 0) allocIdx = i;
        end
        for (int i = 0; i < NB; i++) begin
            if (mState[i] == 1 && mId[i] == commitId) cmtIdx = i;
        end
        if (execReady && mQ.size() > 0) begin
            mState[mQ[0]] = 0;
            void'(mQ.pop_front());
        end
        mSpur = 1'b0;
        if (commitValid) begin
            if (cmtIdx < 0) begin
                mSpur = 1'b1;
            end else if (commitKill) begin
                mState[cmtIdx] = 0;
            end else begin
                mState[cmtIdx] = 2;
                mQ.push_back(cmtIdx);
            end
        end
        if (allocIdx >= 0) begin
            mState[allocIdx] = 1;
            mId[allocIdx]    = issueId;
            mOp[allocIdx]    = issueOp;
            mRs1[allocIdx]   = issueRs1;
            mRs2[allocIdx]   = issueRs2;
            mWb[allocIdx]    = issueWb;
        end
    endtask

    task automatic idle();
        issueValid  = 1'b0;
        issueId     = '0;
        issueAccept = 1'b0;
        issueWb     = 1'b0;
        issueOp     = '0;
        issueRs1    = '0;
        issueRs2    = '0;
        commitValid = 1'b0;
        commitId    = '0;
        commitKill  = 1'b0;
        execReady   = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        issueValid  = v.iv;
        issueId     = v.iid;
        issueAccept = v.acc;
        issueWb     = v.iv;
        issueOp     = v.op;
        issueRs1    = v.rs1;
        issueRs2    = v.rs2;
        commitValid = v.cv;
        commitId    = v.cid;
        commitKill  = v.kill;
        execReady   = v.er;
    endtask

    // Waits for the falling edge and compares every output with the model.
    task automatic checkOutput();
        @(negedge clk);
        checkVal("issue_ready", 32'(issueReady), 32'(modelReady()));
        checkVal("exec_valid", 32'(execValid), 32'(mQ.size() > 0));
        if (mQ.size() > 0) begin
            checkVal("exec_id", 32'(execId), 32'(mId[mQ[0]]));
            checkVal("exec_op", 32'(execOp), 32'(mOp[mQ[0]]));
            checkVal("exec_rs1", execRs1, mRs1[mQ[0]]);
            checkVal("exec_rs2", execRs2, mRs2[mQ[0]]);
            checkVal("exec_wb", 32'(execWb), 32'(mWb[mQ[0]]));
        end
        checkVal("spurious", 32'(spurious), 32'(mSpur));
        checkVal("occupancy", 32'(occupancy), 32'(modelOcc()));
    endtask

    task automatic advance();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic runCycle();
        checkOutput();
        advance();
    endtask

    task automatic issueOne(input logic [3:0] id, input logic [3:0] op, input logic [31:0] rs1);
        idle();
        issueValid  = 1'b1;
        issueId     = id;
        issueAccept = 1'b1;
        issueWb     = 1'b1;
        issueOp     = op;
        issueRs1    = rs1;
        issueRs2    = ~rs1;
        runCycle();
    endtask

    task automatic commitOne(input logic [3:0] id);
        idle();
        commitValid = 1'b1;
        commitId    = id;
        runCycle();
    endtask

    task automatic pulseReset();
        idle();
        rstN = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        logic [3:0] expOrder [3];
        int got;

        //            iv iid acc op rs1    rs2    cv cid kill er | rdy ev id op rs1    rs2    occ spur
        tbl[0]  = '{1, 3, 1, 2, 32'h11, 32'h22, 0, 0, 0, 1,   1, 0, 0, 0, 32'h0,  32'h0,  0, 0};
        tbl[1]  = '{0, 0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 1,   1, 0, 0, 0, 32'h0,  32'h0,  1, 0};
        tbl[2]  = '{0, 0, 0, 0, 32'h0,  32'h0,  1, 3, 0, 1,   1, 0, 0, 0, 32'h0,  32'h0,  1, 0};
        tbl[3]  = '{0, 0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 1,   1, 1, 3, 2, 32'h11, 32'h22, 1, 0};
        tbl[4]  = '{1, 5, 0, 0, 32'h0,  32'h0,  0, 0, 0, 1,   1, 0, 0, 0, 32'h0,  32'h0,  0, 0};
        tbl[5]  = '{1, 6, 1, 1, 32'h5,  32'h6,  0, 0, 0, 1,   1, 0, 0, 0, 32'h0,  32'h0,  0, 0};
        tbl[6]  = '{0, 0, 0, 0, 32'h0,  32'h0,  1, 6, 1, 1,   1, 0, 0, 0, 32'h0,  32'h0,  1, 0};
        tbl[7]  = '{0, 0, 0, 0, 32'h0,  32'h0,  1, 9, 0, 1,   1, 0, 0, 0, 32'h0,  32'h0,  0, 0};
        tbl[8]  = '{0, 0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 1,   1, 0, 0, 0, 32'h0,  32'h0,  0, 1};
        tbl[9]  = '{0, 0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 1,   1, 0, 0, 0, 32'h0,  32'h0,  0, 0};
        tbl[10] = '{0, 0, 0, 0, 32'h0,  32'h0,  1, 3, 0, 1,   1, 0, 0, 0, 32'h0,  32'h0,  0, 0};
        tbl[11] = '{0, 0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 1,   1, 0, 0, 0, 32'h0,  32'h0,  0, 1};

        // Reset release.
        idle();
        rstN = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        checkOutput();
        checkVal("rst_issue_ready", 32'(issueReady), 32'd1);
        checkVal("rst_exec_valid", 32'(execValid), 32'd0);
        checkVal("rst_occupancy", 32'(occupancy), 32'd0);
        advance();

        // Directed vectors: basic flow, reject, kill, spurious commits.
        for (int k = 0; k < 12; k++) begin
            applyStimulus(tbl[k]);
            checkOutput();
            checkVal($sformatf("vec%0d_ready", k), 32'(issueReady), 32'(tbl[k].expReady));
            checkVal($sformatf("vec%0d_exec_valid", k), 32'(execValid), 32'(tbl[k].expEv));
            checkVal($sformatf("vec%0d_occupancy", k), 32'(occupancy), 32'(tbl[k].expOcc));
            checkVal($sformatf("vec%0d_spurious", k), 32'(spurious), 32'(tbl[k].expSpur));
            if (tbl[k].expEv) begin
                checkVal($sformatf("vec%0d_exec_id", k), 32'(execId), 32'(tbl[k].expId));
                checkVal($sformatf("vec%0d_exec_op", k), 32'(execOp), 32'(tbl[k].expOp));
                checkVal($sformatf("vec%0d_exec_rs1", k), execRs1, tbl[k].expRs1);
                checkVal($sformatf("vec%0d_exec_rs2", k), execRs2, tbl[k].expRs2);
                checkVal($sformatf("vec%0d_exec_wb", k), 32'(execWb), 32'd1);
            end
            advance();
        end

        // Full table and duplicate-id stall.
        for (int k = 0; k < 4; k++) issueOne(4'(k), 4'(k), 32'h100 + 32'(k));
        idle();
        issueValid = 1'b1;
        issueId    = 4'd4;
        checkOutput();
        checkVal("full_ready", 32'(issueReady), 32'd0);
        checkVal("full_occupancy", 32'(occupancy), 32'd4);
        advance();
        commitOne(4'd1);
        idle();
        execReady = 1'b1;
        checkOutput();
        checkVal("full_head_id", 32'(execId), 32'd1);
        advance();
        idle();
        issueValid = 1'b1;
        issueId    = 4'd2;
        checkOutput();
        checkVal("dup_ready", 32'(issueReady), 32'd0);
        advance();
        issueValid  = 1'b1;
        issueId     = 4'd4;
        issueAccept = 1'b1;
        checkOutput();
        checkVal("freed_ready", 32'(issueReady), 32'd1);
        advance();
        idle();
        issueValid  = 1'b1;
        issueId     = 4'd2;
        issueAccept = 1'b1;
        commitValid = 1'b1;
        commitId    = 4'd2;
        checkOutput();
        checkVal("dup_pending_ready", 32'(issueReady), 32'd0);
        advance();
        commitValid = 1'b0;
        execReady   = 1'b1;
        checkOutput();
        checkVal("dup_committed_ready", 32'(issueReady), 32'd0);
        advance();
        execReady = 1'b0;
        checkOutput();
        checkVal("dup_freed_ready", 32'(issueReady), 32'd1);
        advance();

        // Reset while two slots are committed.
        commitOne(4'd0);
        commitOne(4'd3);
        idle();
        checkOutput();
        checkVal("pre_reset_exec_valid", 32'(execValid), 32'd1);
        rstN = 1'b0;
        #1;
        checkVal("midrst_exec_valid", 32'(execValid), 32'd0);
        checkVal("midrst_occupancy", 32'(occupancy), 32'd0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;

        // Commit order differs from issue order, with backpressure.
        issueOne(4'd7, 4'd7, 32'h700);
        issueOne(4'd8, 4'd8, 32'h800);
        issueOne(4'd9, 4'd9, 32'h900);
        commitOne(4'd8);
        commitOne(4'd7);
        commitOne(4'd9);
        idle();
        for (int k = 0; k < 4; k++) begin
            checkOutput();
            checkVal($sformatf("stall%0d_exec_id", k), 32'(execId), 32'd8);
            checkVal($sformatf("stall%0d_rs1", k), execRs1, 32'h800);
            advance();
        end
        expOrder[0] = 4'd8;
        expOrder[1] = 4'd7;
        expOrder[2] = 4'd9;
        execReady = 1'b1;
        got = 0;
        for (int k = 0; k < 3; k++) begin
            checkOutput();
            checkVal($sformatf("order%0d_valid", k), 32'(execValid), 32'd1);
            checkVal($sformatf("order%0d_id", k), 32'(execId), 32'(expOrder[k]));
            if (execValid) got++;
            advance();
        end
        checkVal("order_dispatched", 32'(got), 32'd3);
        idle();
        runCycle();

        // Pop, commit and allocation in the same cycle.
        issueOne(4'd1, 4'd1, 32'h10);
        issueOne(4'd2, 4'd2, 32'h20);
        issueOne(4'd10, 4'd10, 32'hA0);
        commitOne(4'd1);
        idle();
        execReady   = 1'b1;
        commitValid = 1'b1;
        commitId    = 4'd2;
        issueValid  = 1'b1;
        issueId     = 4'd4;
        issueAccept = 1'b1;
        issueOp     = 4'd4;
        checkOutput();
        checkVal("simul_ready", 32'(issueReady), 32'd1);
        checkVal("simul_head_id", 32'(execId), 32'd1);
        checkVal("simul_occ_before", 32'(occupancy), 32'd3);
        advance();
        idle();
        checkOutput();
        checkVal("simul_occ_after", 32'(occupancy), 32'd3);
        checkVal("simul_next_head", 32'(execId), 32'd2);
        advance();

        // Randomized traffic against the model.
        pulseReset();
        for (int n = 0; n < 3000; n++) begin
            idle();
            issueValid  = ($urandom_range(0, 1) == 1);
            issueId     = 4'($urandom_range(0, 7));
            issueAccept = ($urandom_range(0, 3) != 0);
            issueWb     = ($urandom_range(0, 1) == 1);
            issueOp     = 4'($urandom);
            issueRs1    = $urandom;
            issueRs2    = $urandom;
            commitValid = ($urandom_range(0, 4) < 2);
            if ($urandom_range(0, 3) != 0) commitId = mId[$urandom_range(0, NB - 1)];
            else commitId = 4'($urandom_range(0, 9));
            commitKill  = ($urandom_range(0, 3) == 0);
            execReady   = ($urandom_range(0, 4) < 3);
            runCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
